// File: rtl/regfile_rename_pkg.sv
// Shared constants for the rename-tagged architectural register file.
// Optional build feature: define RF_COMMIT_CNT_EN to enable the debug
// commit counter in regfile_rename.
package regfile_rename_pkg;

  localparam int RF_DATA_W  = 32;  // register data width
  localparam int RF_NAME_W  = 5;   // architectural register index width
  localparam int RF_NICK_W  = 5;   // ROB nick width
  localparam int RF_REG_NUM = 32;  // number of architectural registers
  localparam int NO_NICK    = 0;   // nick value meaning "no producer"
  localparam int ZERO_REG   = 0;   // hard-wired zero register index

endpackage

// File: rtl/regfile_rename_rf_read_port.sv
// One dispatch lookup port: applies the x0 rule, the same-cycle commit
// bypass, and the busy/nick/data exclusivity on a single register entry.
module rf_read_port
  import regfile_rename_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int NAME_W = RF_NAME_W,
  parameter int NICK_W = RF_NICK_W
) (
  input  logic [NAME_W-1:0] regnm,
  input  logic              ent_busy,
  input  logic [NICK_W-1:0] ent_tag,
  input  logic [DATA_W-1:0] ent_dt,
  input  logic              cm_en,
  input  logic [NAME_W-1:0] cm_regnm,
  input  logic [NICK_W-1:0] cm_nick,
  input  logic [DATA_W-1:0] cm_dt,
  output logic              busy,
  output logic [NICK_W-1:0] nick,
  output logic [DATA_W-1:0] dt
);

  logic is_x0;
  logic cm_hit;

  // Resolve the entry: x0 reads zero, a commit retiring the newest producer
  // forwards its data, otherwise report the stored tag or value.
  always_comb begin
    is_x0  = (regnm == NAME_W'(ZERO_REG));
    cm_hit = cm_en && (cm_regnm == regnm) && !is_x0 && (ent_tag == cm_nick);
    busy   = 1'b0;
    nick   = NICK_W'(NO_NICK);
    dt     = '0;
    if (is_x0) begin
      busy = 1'b0;
    end else if (cm_hit) begin
      dt = cm_dt;
    end else if (ent_busy) begin
      busy = 1'b1;
      nick = ent_tag;
    end else begin
      dt = ent_dt;
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags. Records the
// producing ROB nick at issue, retires data at commit, and releases the tag
// only when the committing nick is still the newest producer.
// Optional feature macro: RF_COMMIT_CNT_EN (debug accepted-commit counter).
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int NAME_W  = RF_NAME_W,
  parameter int NICK_W  = RF_NICK_W,
  parameter int REG_NUM = RF_REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iROB_nick_en,
  input  logic [NICK_W-1:0] iROB_nick,
  input  logic [NAME_W-1:0] iROB_nick_regnm,
  input  logic              iRF_en,
  input  logic [NAME_W-1:0] iRF_rd_regnm,
  input  logic [DATA_W-1:0] iRF_rd_dt,
  input  logic [NICK_W-1:0] iRF_rd_nick,
  input  logic [NAME_W-1:0] iDP_rs1_regnm,
  input  logic [NAME_W-1:0] iDP_rs2_regnm,
  output logic              oDP_rs1_busy,
  output logic [NICK_W-1:0] oDP_rs1_nick,
  output logic [DATA_W-1:0] oDP_rs1_dt,
  output logic              oDP_rs2_busy,
  output logic [NICK_W-1:0] oDP_rs2_nick,
  output logic [DATA_W-1:0] oDP_rs2_dt,
  output logic [31:0]       oDBG_commit_cnt
);

  logic [DATA_W-1:0]  data_q [REG_NUM];
  logic [DATA_W-1:0]  data_d [REG_NUM];
  logic [NICK_W-1:0]  tag_q  [REG_NUM];
  logic [NICK_W-1:0]  tag_d  [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  logic              rs1_busy, rs2_busy;
  logic [NICK_W-1:0] rs1_nick, rs2_nick;
  logic [DATA_W-1:0] rs1_dt,   rs2_dt;

  // Next state: commit writes data and may release the tag; a same-cycle
  // rename then overrides tag/busy; flush clears all tags but keeps data.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (iRF_en && (iRF_rd_regnm != NAME_W'(ZERO_REG))) begin
      data_d[iRF_rd_regnm] = iRF_rd_dt;
      if (tag_q[iRF_rd_regnm] == iRF_rd_nick) begin
        busy_d[iRF_rd_regnm] = 1'b0;
        tag_d[iRF_rd_regnm]  = NICK_W'(NO_NICK);
      end
    end
    if (clr) begin
      busy_d = '0;
      for (int i = 0; i < REG_NUM; i++) tag_d[i] = NICK_W'(NO_NICK);
    end else if (iROB_nick_en && (iROB_nick_regnm != NAME_W'(ZERO_REG)) &&
                 (iROB_nick != NICK_W'(NO_NICK))) begin
      busy_d[iROB_nick_regnm] = 1'b1;
      tag_d[iROB_nick_regnm]  = iROB_nick;
    end
  end

  // Register file state: cleared by reset, frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '{default: '0};
      tag_q  <= '{default: '0};
      busy_q <= '0;
    end else if (rdy) begin
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .NAME_W(NAME_W), .NICK_W(NICK_W)) u_rs1 (
    .regnm    (iDP_rs1_regnm),
    .ent_busy (busy_q[iDP_rs1_regnm]),
    .ent_tag  (tag_q[iDP_rs1_regnm]),
    .ent_dt   (data_q[iDP_rs1_regnm]),
    .cm_en    (iRF_en),
    .cm_regnm (iRF_rd_regnm),
    .cm_nick  (iRF_rd_nick),
    .cm_dt    (iRF_rd_dt),
    .busy     (rs1_busy),
    .nick     (rs1_nick),
    .dt       (rs1_dt)
  );

  rf_read_port #(.DATA_W(DATA_W), .NAME_W(NAME_W), .NICK_W(NICK_W)) u_rs2 (
    .regnm    (iDP_rs2_regnm),
    .ent_busy (busy_q[iDP_rs2_regnm]),
    .ent_tag  (tag_q[iDP_rs2_regnm]),
    .ent_dt   (data_q[iDP_rs2_regnm]),
    .cm_en    (iRF_en),
    .cm_regnm (iRF_rd_regnm),
    .cm_nick  (iRF_rd_nick),
    .cm_dt    (iRF_rd_dt),
    .busy     (rs2_busy),
    .nick     (rs2_nick),
    .dt       (rs2_dt)
  );

  // Lookups read as all-zero while reset is asserted.
  always_comb begin
    oDP_rs1_busy = 1'b0;
    oDP_rs1_nick = '0;
    oDP_rs1_dt   = '0;
    oDP_rs2_busy = 1'b0;
    oDP_rs2_nick = '0;
    oDP_rs2_dt   = '0;
    if (rst) begin
      oDP_rs1_busy = rs1_busy;
      oDP_rs1_nick = rs1_nick;
      oDP_rs1_dt   = rs1_dt;
      oDP_rs2_busy = rs2_busy;
      oDP_rs2_nick = rs2_nick;
      oDP_rs2_dt   = rs2_dt;
    end
  end

`ifdef RF_COMMIT_CNT_EN
  logic [31:0] commit_cnt_q;
  logic [31:0] commit_cnt_d;

  // Count every accepted commit, x0 included; flush does not touch it.
  always_comb begin
    commit_cnt_d = commit_cnt_q + (iRF_en ? 32'd1 : 32'd0);
  end

  // Counter register: cleared by reset, frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      commit_cnt_q <= '0;
    end else if (rdy) begin
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign oDBG_commit_cnt = commit_cnt_q;
`else
  assign oDBG_commit_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_rename.sv
// Self-checking bench for regfile_rename: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_regfile_rename;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        nick_en;
  logic [4:0]  nick, nregnm;
  logic        rf_en;
  logic [4:0]  rd, rnick;
  logic [31:0] rdt;
  logic [4:0]  rs1, rs2;
  logic        o1_busy, o2_busy;
  logic [4:0]  o1_nick, o2_nick;
  logic [31:0] o1_dt, o2_dt, o_cnt;

  int n_total = 0;
  int n_pass  = 0;
  logic check_en = 1'b0;

  // behavioural model: value, newest outstanding producer (0 = none)
  logic [31:0] m_data [32] = '{default: '0};
  logic [4:0]  m_prod [32] = '{default: '0};
  logic [31:0] m_cnt = '0;

  always #5 clk = ~clk;

  regfile_rename dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .iROB_nick_en(nick_en), .iROB_nick(nick), .iROB_nick_regnm(nregnm),
    .iRF_en(rf_en), .iRF_rd_regnm(rd), .iRF_rd_dt(rdt), .iRF_rd_nick(rnick),
    .iDP_rs1_regnm(rs1), .iDP_rs2_regnm(rs2),
    .oDP_rs1_busy(o1_busy), .oDP_rs1_nick(o1_nick), .oDP_rs1_dt(o1_dt),
    .oDP_rs2_busy(o2_busy), .oDP_rs2_nick(o2_nick), .oDP_rs2_dt(o2_dt),
    .oDBG_commit_cnt(o_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] n);
`ifdef RF_COMMIT_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  // What dispatch must see for register r given model state and this cycle's commit
  task automatic exp_lookup(input logic [4:0] r, output logic b, output logic [4:0] n,
                            output logic [31:0] d);
    b = 1'b0; n = 5'd0; d = 32'd0;
    if (rst && r != 5'd0) begin
      if (rf_en && rd == r && m_prod[r] == rnick) d = rdt;
      else if (m_prod[r] != 5'd0) begin b = 1'b1; n = m_prod[r]; end
      else d = m_data[r];
    end
  endtask

  // model update at each clock edge
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin m_data[i] = 32'd0; m_prod[i] = 5'd0; end
      m_cnt = 32'd0;
    end else if (rdy) begin
      if (rf_en) m_cnt = m_cnt + 32'd1;
      if (rf_en && rd != 5'd0) begin
        m_data[rd] = rdt;
        if (m_prod[rd] == rnick) m_prod[rd] = 5'd0;
      end
      if (clr) begin
        for (int i = 0; i < 32; i++) m_prod[i] = 5'd0;
      end else if (nick_en && nregnm != 5'd0 && nick != 5'd0) begin
        m_prod[nregnm] = nick;
      end
    end
  end

  // compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    logic b; logic [4:0] n; logic [31:0] d;
    if (check_en) begin
      exp_lookup(rs1, b, n, d);
      chk("m_rs1_busy", o1_busy, b); chk("m_rs1_nick", o1_nick, n); chk("m_rs1_dt", o1_dt, d);
      exp_lookup(rs2, b, n, d);
      chk("m_rs2_busy", o2_busy, b); chk("m_rs2_nick", o2_nick, n); chk("m_rs2_dt", o2_dt, d);
      chk("m_cnt", o_cnt, cnt_exp(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    clr = 1'b0; nick_en = 1'b0; nick = '0; nregnm = '0;
    rf_en = 1'b0; rd = '0; rdt = '0; rnick = '0;
  endtask

  task automatic rename(input logic [4:0] r, input logic [4:0] k);
    nick_en = 1'b1; nregnm = r; nick = k;
  endtask

  task automatic commit(input logic [4:0] r, input logic [31:0] d, input logic [4:0] k);
    rf_en = 1'b1; rd = r; rdt = d; rnick = k;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle(); rdy = 1'b1; rst = 1'b0; rs1 = 5'd5; rs2 = 5'd0;
    step(); check_en = 1'b1; step();
    #1 chk("inrst_rs1_busy", o1_busy, 0); chk("inrst_rs1_dt", o1_dt, 0);
    rst = 1'b1; step();
    #1 chk("rst_rs1_busy", o1_busy, 0); chk("rst_rs1_nick", o1_nick, 0);
    chk("rst_rs1_dt", o1_dt, 0); chk("rst_rs2_busy", o2_busy, 0);
    chk("rst_rs2_dt", o2_dt, 0); chk("rst_cnt", o_cnt, 0);

    // rename then commit x5
    rename(5'd5, 5'd3); step(); idle();
    #1 chk("x5_busy", o1_busy, 1); chk("x5_nick", o1_nick, 3); chk("x5_dt_busy", o1_dt, 0);
    commit(5'd5, 32'hDEADBEEF, 5'd3);
    #1 chk("x5_byp_busy", o1_busy, 0); chk("x5_byp_dt", o1_dt, 32'hDEADBEEF);
    step(); idle();
    #1 chk("x5_cm_busy", o1_busy, 0); chk("x5_cm_nick", o1_nick, 0); chk("x5_cm_dt", o1_dt, 32'hDEADBEEF);

    // stale commit on x7 keeps newer tag
    rs1 = 5'd7; rename(5'd7, 5'd2); step(); rename(5'd7, 5'd4); step(); idle();
    commit(5'd7, 32'h11, 5'd2);
    #1 chk("x7_stale_busy", o1_busy, 1); chk("x7_stale_nick", o1_nick, 4);
    step(); idle();
    #1 chk("x7_after_stale_nick", o1_nick, 4);
    commit(5'd7, 32'h22, 5'd4); step(); idle();
    #1 chk("x7_busy", o1_busy, 0); chk("x7_dt", o1_dt, 32'h22);

    // same-cycle bypass on rs2
    rename(5'd9, 5'd6); step(); idle();
    commit(5'd9, 32'h55, 5'd6); rs2 = 5'd9;
    #1 chk("x9_byp_busy", o2_busy, 0); chk("x9_byp_nick", o2_nick, 0); chk("x9_byp_dt", o2_dt, 32'h55);
    step(); idle();

    // flush with commit and rename in the same cycle
    rename(5'd1, 5'd1); step(); rename(5'd2, 5'd2); step(); idle();
    clr = 1'b1; commit(5'd1, 32'hA, 5'd1); rename(5'd3, 5'd3); step(); idle();
    rs1 = 5'd1; rs2 = 5'd2;
    #1 chk("clr_x1_busy", o1_busy, 0); chk("clr_x1_dt", o1_dt, 32'hA);
    chk("clr_x2_busy", o2_busy, 0); chk("clr_x2_dt", o2_dt, 0);
    rs1 = 5'd3;
    #1 chk("clr_x3_busy", o1_busy, 0); chk("clr_x3_nick", o1_nick, 0);

    // x0 rename/commit ignored; counter counts it
    rs1 = 5'd0; rename(5'd0, 5'd8); commit(5'd0, 32'hFF, 5'd8);
    #1 chk("x0_byp_dt", o1_dt, 0);
    step(); idle();
    #1 chk("x0_busy", o1_busy, 0); chk("x0_dt", o1_dt, 0); chk("x0_cnt", o_cnt, cnt_exp(32'd6));

    // rdy low: nothing changes
    rdy = 1'b0; rs1 = 5'd4; commit(5'd4, 32'h44, 5'd0); rename(5'd4, 5'd9);
    repeat (3) step();
    idle();
    #1 chk("stall_busy", o1_busy, 0); chk("stall_dt", o1_dt, 0); chk("stall_cnt", o_cnt, cnt_exp(32'd6));
    rdy = 1'b1; step();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      rst     = ($urandom_range(0, 199) != 0);
      rdy     = ($urandom_range(0, 9) != 0);
      clr     = ($urandom_range(0, 29) == 0);
      nick_en = 1'($urandom_range(0, 1));
      nregnm  = pick_reg();
      nick    = 5'($urandom_range(0, 31));
      rf_en   = 1'($urandom_range(0, 1));
      rd      = pick_reg();
      rdt     = $urandom;
      rnick   = ($urandom_range(0, 9) < 6) ? m_prod[rd] : 5'($urandom_range(0, 31));
      rs1     = pick_reg();
      rs2     = ($urandom_range(0, 3) == 0) ? rd : pick_reg();
      step();
    end
    idle(); rst = 1'b1; rdy = 1'b1;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags. It is the consumer end of the ROB's nick-issue and commit interfaces.
- At issue it records which ROB nick will produce each destination register.
- At commit it writes retired data and releases the tag only if that nick is still the newest one for the register.
- Provides two combinational source lookups (busy/nick/data) to dispatch; clears all tags on ROB flush.

Parameters:
- DATA_W, 32, register data width (`DataBus`)
- NAME_W, 5, architectural register index width (`NameBus`)
- NICK_W, 5, ROB nick width (`NickBus`); nick 0 = no tag, valid nicks 1..31
- REG_NUM, 32, number of architectural registers

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-low reset
- rdy  in  1  global ready; when low, all state holds
- clr  in  1  ROB flush (mispredict)
- iROB_nick_en  in  1  rename request valid
- iROB_nick  in  NICK_W  nick allocated to the issuing instruction
- iROB_nick_regnm  in  NAME_W  destination register being renamed
- iRF_en  in  1  commit valid
- iRF_rd_regnm  in  NAME_W  committed destination register
- iRF_rd_dt  in  DATA_W  committed data
- iRF_rd_nick  in  NICK_W  nick of the committing entry
- iDP_rs1_regnm  in  NAME_W  source 1 lookup index
- iDP_rs2_regnm  in  NAME_W  source 2 lookup index
- oDP_rs1_busy  out  1  source 1 awaiting a producer
- oDP_rs1_nick  out  NICK_W  producer nick when busy, else 0
- oDP_rs1_dt  out  DATA_W  register value when not busy, else 0
- oDP_rs2_busy, oDP_rs2_nick, oDP_rs2_dt  out  1/NICK_W/DATA_W  same as rs1
- oDBG_commit_cnt  out  32  accepted-commit counter (see Optional Feature)

Behaviour:
- State: data[REG_NUM], busy[REG_NUM], tag[REG_NUM].
- Reset: rst==0 at posedge clears all data, busy and tag to 0. While rst==0, every lookup output reads 0.
- rdy==0: no state changes at that edge; lookup outputs remain driven from current state.
- Register 0 (x0): data always 0, never busy. Rename and commit targeting regnm 0 are ignored.
- Rename with nick 0 is ignored.
- Rename (iROB_nick_en, regnm!=0): next edge busy<=1, tag<=nick. A later rename of the same register overwrites the tag.
- Commit (iRF_en, regnm!=0): next edge data<=dt.
  - If tag==iRF_rd_nick: busy<=0, tag<=0.
  - Otherwise tag and busy are unchanged (a newer producer is outstanding).
- Rename and commit to the same register in the same cycle: data is written, and the rename's tag/busy win (busy=1, tag=new nick).
- clr: next edge all busy<=0 and tag<=0. Data is kept.
  - A commit in the clr cycle is still written (it is retired).
  - A rename in the clr cycle is dropped.
- Lookup is combinational and reflects state before this cycle's rename, so an instruction never sees its own rename.
- Same-cycle commit bypass on lookup, when iRF_en, regnm matches, regnm!=0, and tag==iRF_rd_nick:
  - busy=0, nick=0, dt=iRF_rd_dt.
  - Ensures dispatch never waits on a nick already broadcast.
- busy==0 ⇒ nick output 0. busy==1 ⇒ dt output 0.
- Latency: rename and commit visible at lookup one cycle after the edge (commit visible same cycle via bypass).

Optional Feature:
- Macro RF_COMMIT_CNT_EN.
- Defined:
  - oDBG_commit_cnt increments by 1 at each edge with rdy && rst && iRF_en, including regnm 0.
  - Wraps at 2^32. Reset to 0. Not affected by clr.
- Undefined: oDBG_commit_cnt tied to 0 and no counter flops are inferred.

Decomposition:
- Shared config.v holds:
  - `DataBus`, `NameBus`, `NickBus`
  - `RegNum` (32)
  - `NoNick` (0)
  - `ZeroReg` (0)
- One sub-module, rf_read_port, instantiated twice (rs1/rs2):
  - Inputs: lookup index, the busy/tag/data entry, and the commit bus.
  - Produces busy/nick/dt including the bypass and x0 rules.

Test Plan:
- Reset, then lookup rs1=5, rs2=0 -> busy=0, nick=0, dt=0 on both.
- Rename x5←nick 3; next cycle lookup rs1=5 -> busy=1, nick=3. Commit(x5, 0xDEADBEEF, nick 3); next cycle -> busy=0, dt=0xDEADBEEF.
- Rename x7←nick 2, then x7←nick 4. Commit(x7, 0x11, nick 2) -> data=0x11 but busy=1, nick=4. Commit(x7, 0x22, nick 4) -> busy=0, dt=0x22.
- Busy x9 (nick 6); in a cycle with commit(x9, 0x55, nick 6) and lookup rs2=9 -> same-cycle busy=0, dt=0x55.
- Rename x1/nick 1, x2/nick 2. Assert clr together with commit(x1, 0xA, nick 1) and rename x3/nick 3 -> next cycle x1 dt=0xA not busy, x2 not busy dt=old, x3 not busy.
- Rename x0←nick 8 and commit(x0, 0xFF, nick 8) -> x0 stays busy=0, dt=0. With RF_COMMIT_CNT_EN, the counter rises by 1; with rdy=0 for 3 cycles during commits, no changes.
